writeback_unit: RTL and testbench

Execute-to-writeback stage placed directly downstream of the ALU. Captures one ALU result per handshake and, depending on opcode and condition outcome, does one of four things: writes the register file, performs a data-memory load or store, latches flags into the status register, or drops the operation. Holds the pipeline with a valid/ready handshake while a memory access is outstanding. Keeps a retired-operation counter for debug.

---
 rtl/writeback_unit.sv | 153 +++++++++++++++
 tb/tb_writeback_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Execute-to-writeback stage: retires ALU results to the register file, runs
// data-memory loads/stores under a valid/ready handshake, latches status flags.
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [3:0]        Opcode,
  input  logic              Condition_met,
  input  logic              S,
  input  logic [DATA_W-1:0] Alu_out,
  input  logic [3:0]        Alu_flags,
  input  logic [REG_AW-1:0] Rd,
  input  logic [DATA_W-1:0] Store_data,
  output logic              Mem_req,
  output logic              Mem_we,
  output logic [DATA_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_wdata,
  input  logic              Mem_ack,
  input  logic [DATA_W-1:0] Mem_rdata,
  output logic              Rf_we,
  output logic [REG_AW-1:0] Rf_waddr,
  output logic [DATA_W-1:0] Rf_wdata,
  output logic [3:0]        Status,
  output logic [CNT_W-1:0]  Retired
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [3:0]        status_q, status_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic accept;
  logic is_alu, is_cmp, is_ldr, is_str, is_known;

  assign In_ready = ~reset & (state_q != ST_MEM);
  assign accept   = In_valid & In_ready;
  assign is_alu   = ~Opcode[3];
  assign is_cmp   = (Opcode == OP_CMP);
  assign is_ldr   = (Opcode == OP_LDR);
  assign is_str   = (Opcode == OP_STR);
  assign is_known = is_alu | is_cmp | is_ldr | is_str;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    status_d    = status_q;
    retired_d   = retired_q;

    // The write-back cycle itself retires the op, whatever gets accepted alongside it.
    if (state_q == ST_WB) retired_d = retired_q + CNT_W'(1);

    case (state_q)
      ST_MEM: begin
        if (Mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d   = ST_IDLE;
            retired_d = retired_q + CNT_W'(1);
          end else begin
            rf_wdata_d = Mem_rdata;
            state_d    = ST_WB;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept && Condition_met && is_known) begin
          if (S || is_cmp) status_d = Alu_flags;
          if (is_alu) begin
            rf_waddr_d = Rd;
            rf_wdata_d = Alu_out;
            state_d    = ST_WB;
          end else if (is_ldr) begin
            mem_addr_d = Alu_out;
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            rf_waddr_d = Rd;
            state_d    = ST_MEM;
          end else if (is_str) begin
            mem_addr_d  = Alu_out;
            mem_wdata_d = Store_data;
            mem_we_d    = 1'b1;
            mem_req_d   = 1'b1;
            state_d     = ST_MEM;
          end
        end
      end
    endcase

    rf_we_d = (state_d == ST_WB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      status_q    <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      status_q    <= status_d;
      retired_q   <= retired_d;
    end
  end

  assign Mem_req   = mem_req_q;
  assign Mem_we    = mem_we_q;
  assign Mem_addr  = mem_addr_q;
  assign Mem_wdata = mem_wdata_q;
  assign Rf_we     = rf_we_q;
  assign Rf_waddr  = rf_waddr_q;
  assign Rf_wdata  = rf_wdata_q;
  assign Status    = status_q;
  assign Retired   = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected register and
// memory transactions, a negedge monitor pops and compares them.
module tb_writeback_unit;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              In_valid;
  logic              In_ready;
  logic [3:0]        Opcode;
  logic              Condition_met;
  logic              S;
  logic [DATA_W-1:0] Alu_out;
  logic [3:0]        Alu_flags;
  logic [REG_AW-1:0] Rd;
  logic [DATA_W-1:0] Store_data;
  logic              Mem_req;
  logic              Mem_we;
  logic [DATA_W-1:0] Mem_addr;
  logic [DATA_W-1:0] Mem_wdata;
  logic              Mem_ack;
  logic [DATA_W-1:0] Mem_rdata;
  logic              Rf_we;
  logic [REG_AW-1:0] Rf_waddr;
  logic [DATA_W-1:0] Rf_wdata;
  logic [3:0]        Status;
  logic [CNT_W-1:0]  Retired;

  writeback_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .In_valid(In_valid), .In_ready(In_ready),
    .Opcode(Opcode), .Condition_met(Condition_met), .S(S), .Alu_out(Alu_out),
    .Alu_flags(Alu_flags), .Rd(Rd), .Store_data(Store_data),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Mem_ack(Mem_ack), .Mem_rdata(Mem_rdata),
    .Rf_we(Rf_we), .Rf_waddr(Rf_waddr), .Rf_wdata(Rf_wdata),
    .Status(Status), .Retired(Retired)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mem_cycles = 0;

  logic [REG_AW+DATA_W-1:0]   rf_q[$];
  logic [2*DATA_W:0]          mem_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: compare every register write and every memory request cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (Rf_we === 1'b1) begin
        if (rf_q.size() == 0) begin
          check("unexpected_rf_we", 1, 0);
        end else begin
          logic [REG_AW+DATA_W-1:0] e;
          e = rf_q.pop_front();
          $display("rf write r%0d <= %h", Rf_waddr, Rf_wdata);
          check("rf_waddr", 64'(Rf_waddr), 64'(e[REG_AW+DATA_W-1:DATA_W]));
          check("rf_wdata", 64'(Rf_wdata), 64'(e[DATA_W-1:0]));
        end
      end
      if (Mem_req === 1'b1) begin
        mem_cycles++;
        check("in_ready_in_mem", 64'(In_ready), 0);
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", 1, 0);
        end else begin
          logic [2*DATA_W:0] m;
          m = mem_q[0];
          check("mem_we", 64'(Mem_we), 64'(m[2*DATA_W]));
          check("mem_addr", 64'(Mem_addr), 64'(m[2*DATA_W-1:DATA_W]));
          if (m[2*DATA_W]) check("mem_wdata", 64'(Mem_wdata), 64'(m[DATA_W-1:0]));
          if (Mem_ack === 1'b1) begin
            void'(mem_q.pop_front());
            $display("mem %s addr %h done", Mem_we ? "store" : "load", Mem_addr);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic cond, input logic s,
                       input logic [31:0] alu, input logic [3:0] fl,
                       input logic [3:0] rd, input logic [31:0] sd);
    int w;
    In_valid = 1'b1; Opcode = op; Condition_met = cond; S = s;
    Alu_out = alu; Alu_flags = fl; Rd = rd; Store_data = sd;
    if (cond && !op[3]) rf_q.push_back({rd, alu});
    if (cond && op == 4'b1101) mem_q.push_back({1'b0, alu, 32'h0});
    if (cond && op == 4'b1110) mem_q.push_back({1'b1, alu, sd});
    w = 0;
    while (In_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    In_valid = 1'b0;
    $display("issue op=%b cond=%0d s=%0d alu=%h rd=%0d", op, cond, s, alu, rd);
  endtask

  task automatic idle(input int n);
    In_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1; In_valid = 1'b0; Opcode = '0; Condition_met = 1'b0; S = 1'b0;
    Alu_out = '0; Alu_flags = '0; Rd = '0; Store_data = '0;
    Mem_ack = 1'b0; Mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(In_ready), 0);
    check("rst_mem_req", 64'(Mem_req), 0);
    check("rst_rf_we", 64'(Rf_we), 0);
    check("rst_status", 64'(Status), 0);
    check("rst_retired", 64'(Retired), 0);
    reset = 1'b0;
    #1 check("in_ready_after_rst", 64'(In_ready), 1);

    // Back-to-back ADD stream: one write per cycle.
    issue(4'b0100, 1, 0, 32'd5, 4'h0, 4'd1, 0);
    issue(4'b0100, 1, 0, 32'd7, 4'h0, 4'd2, 0);
    check("stream_in_ready", 64'(In_ready), 1);
    issue(4'b0100, 1, 0, 32'd9, 4'h0, 4'd3, 0);
    check("stream_retired_mid", 64'(Retired), 2);
    idle(1);
    check("stream_retired", 64'(Retired), 3);

    // Flags and condition handling.
    issue(4'b1011, 1, 0, 32'h0, 4'b0100, 4'd4, 0);
    check("cmp_status", 64'(Status), 64'h4);
    check("cmp_no_rf_we", 64'(Rf_we), 0);
    issue(4'b0100, 1, 0, 32'h11, 4'b1111, 4'd7, 0);
    check("add_s0_status", 64'(Status), 64'h4);
    idle(1);
    issue(4'b0010, 0, 1, 32'h22, 4'b1010, 4'd8, 0);
    check("sub_nc_rf_we", 64'(Rf_we), 0);
    check("sub_nc_status", 64'(Status), 64'h4);
    idle(1);
    check("sub_nc_retired", 64'(Retired), 4);

    // Load with wait states: ack sampled on the third MEM cycle.
    c0 = mem_cycles;
    issue(4'b1101, 1, 0, 32'h100, 4'h0, 4'd5, 0);
    idle(2);
    Mem_ack = 1'b1; Mem_rdata = 32'hDEADBEEF;
    rf_q.push_back({4'd5, 32'hDEADBEEF});
    @(posedge clk); #1;
    Mem_ack = 1'b0;
    check("ldr_req_cycles", 64'(mem_cycles - c0), 3);
    check("ldr_rf_we", 64'(Rf_we), 1);
    check("ldr_req_low", 64'(Mem_req), 0);
    check("ldr_in_ready", 64'(In_ready), 1);
    idle(1);
    check("ldr_retired", 64'(Retired), 5);

    // Store with ack in the first MEM cycle.
    c0 = mem_cycles;
    issue(4'b1110, 1, 0, 32'h200, 4'h0, 4'd9, 32'h1234);
    Mem_ack = 1'b1;
    @(posedge clk); #1;
    Mem_ack = 1'b0;
    check("str_req_cycles", 64'(mem_cycles - c0), 1);
    check("str_retired", 64'(Retired), 6);
    check("str_no_rf_we", 64'(Rf_we), 0);
    idle(1);
    check("str_no_rf_we_late", 64'(Rf_we), 0);

    // Reset during an outstanding load, then a late ack.
    issue(4'b1101, 1, 0, 32'h300, 4'h0, 4'd6, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    mem_q.delete();
    reset = 1'b0;
    Mem_ack = 1'b1; Mem_rdata = 32'hCAFEF00D;
    check("rstmem_req", 64'(Mem_req), 0);
    check("rstmem_status", 64'(Status), 0);
    check("rstmem_retired", 64'(Retired), 0);
    check("rstmem_addr", 64'(Mem_addr), 0);
    @(posedge clk); #1;
    Mem_ack = 1'b0;
    check("rstmem_late_ack_rf_we", 64'(Rf_we), 0);
    check("rstmem_late_ack_req", 64'(Mem_req), 0);
    check("rstmem_rf_wdata", 64'(Rf_wdata), 0);
    check("rstmem_in_ready", 64'(In_ready), 1);
    idle(1);
    check("rstmem_rf_we_later", 64'(Rf_we), 0);

    // Counter wrap with a 4-bit counter: 17 retirements leave 1.
    for (int i = 0; i < 17; i++) issue(4'b0000, 1, 0, 32'(i + 32'h40), 4'h0, 4'(i), 0);
    idle(1);
    check("wrap_retired", 64'(Retired), 1);

    idle(2);
    check("rf_queue_drained", 64'(rf_q.size()), 0);
    check("mem_queue_drained", 64'(mem_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
